// File: rtl/alphabet_rank_engine.sv
// alphabet_rank_engine: ranks a latched glove sample against stored letter templates by sum of absolute differences; define RANK_RUNNER_UP_EN to add runner-up outputs
module alphabet_rank_engine #(
    parameter int DATA_W = 15,
    parameter int N_CH = 5,
    parameter int N_LETTERS = 26,
    parameter int LW = (N_LETTERS > 1) ? $clog2(N_LETTERS) : 1,
    parameter int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int SCORE_W = DATA_W + $clog2(N_CH),
    parameter logic [SCORE_W-1:0] MATCH_THRESH = {SCORE_W{1'b1}}
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ref_we,
    input  logic [LW-1:0]            ref_letter,
    input  logic [CW-1:0]            ref_ch,
    input  logic [DATA_W-1:0]        ref_data,
    input  logic                     ref_clr,
    input  logic                     start,
    input  logic [N_CH*DATA_W-1:0]   sensor_in,
    output logic                     busy,
    output logic                     done,
    output logic [LW-1:0]            best_letter,
    output logic [SCORE_W-1:0]       best_score,
    output logic                     no_match
`ifdef RANK_RUNNER_UP_EN
    ,
    output logic [LW-1:0]            second_letter,
    output logic [SCORE_W-1:0]       second_score
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] ram [N_LETTERS][N_CH];
    logic [DATA_W-1:0] smp [N_CH];
    logic [N_LETTERS-1:0] valid;
    logic [LW-1:0] l, best_l, nl;
    logic [CW-1:0] c;
    logic [SCORE_W-1:0] acc, best, fin, nb;
    logic [DATA_W-1:0] s_v, r_v, term;
    logic found, upd, nf, last_ch, last, wr_ok, accept;

    assign wr_ok = ref_we && state == IDLE && {1'b0, ref_letter} < (LW+1)'(N_LETTERS)
                   && {1'b0, ref_ch} < (CW+1)'(N_CH);
    assign accept = state == IDLE && start;
    assign s_v = smp[c];
    assign r_v = ram[l][c];
    assign term = s_v > r_v ? s_v - r_v : r_v - s_v;
    assign fin = acc + SCORE_W'(term);
    assign last_ch = c == CW'(N_CH - 1);
    assign last = last_ch && l == LW'(N_LETTERS - 1);
    assign upd = valid[l] && (!found || fin < best);
    assign nb = upd ? fin : best;
    assign nl = upd ? l : best_l;
    assign nf = found | upd;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end

    // Next-state and status strobes
    always_comb begin
        state_nx = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_nx = start ? SCAN : IDLE;
            SCAN: begin
                busy = 1'b1;
                state_nx = last ? DONE : SCAN;
            end
            DONE: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Template storage; unreset, written only while idle
    always_ff @(posedge CLK) begin
        if (wr_ok) ram[ref_letter][ref_ch] <= ref_data;
    end

    // Letter-valid bits; a clear and a write in one cycle leaves the written letter valid
    always_ff @(posedge CLK) begin
        if (RST) valid <= '0;
        else if (state == IDLE) begin
            if (ref_clr) valid <= '0;
            if (wr_ok) valid[ref_letter] <= 1'b1;
        end
    end

    // Scan datapath: per-channel accumulation, running best, result latch on the final term
    always_ff @(posedge CLK) begin
        if (RST) begin
            l <= '0;
            c <= '0;
            acc <= '0;
            best <= '1;
            best_l <= '1;
            found <= 1'b0;
            best_letter <= '0;
            best_score <= '0;
            no_match <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N_CH; i++) smp[i] <= sensor_in[i*DATA_W +: DATA_W];
            l <= '0;
            c <= '0;
            acc <= '0;
            best <= '1;
            best_l <= '1;
            found <= 1'b0;
        end else if (state == SCAN) begin
            if (last_ch) begin
                acc <= '0;
                c <= '0;
                l <= l + 1'b1;
                best <= nb;
                best_l <= nl;
                found <= nf;
            end else begin
                acc <= fin;
                c <= c + 1'b1;
            end
            if (last) begin
                best_letter <= nf ? nl : '1;
                best_score <= nf ? nb : '1;
                no_match <= !nf || nb > MATCH_THRESH;
            end
        end
    end

`ifdef RANK_RUNNER_UP_EN
    logic [SCORE_W-1:0] sec, sec_nx;
    logic [LW-1:0] sec_l, sec_l_nx;
    logic found2, f2_nx, demote, upd2;

    assign demote = upd && found;
    assign upd2 = valid[l] && found && !upd && (!found2 || fin < sec);
    assign sec_nx = demote ? best : upd2 ? fin : sec;
    assign sec_l_nx = demote ? best_l : upd2 ? l : sec_l;
    assign f2_nx = found2 | demote | upd2;

    // Runner-up tracking: a displaced best drops to second
    always_ff @(posedge CLK) begin
        if (RST) begin
            sec <= '1;
            sec_l <= '1;
            found2 <= 1'b0;
            second_letter <= '0;
            second_score <= '0;
        end else if (accept) begin
            sec <= '1;
            sec_l <= '1;
            found2 <= 1'b0;
        end else if (state == SCAN) begin
            if (last_ch) begin
                sec <= sec_nx;
                sec_l <= sec_l_nx;
                found2 <= f2_nx;
            end
            if (last) begin
                second_letter <= f2_nx ? sec_l_nx : '1;
                second_score <= f2_nx ? sec_nx : '1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alphabet_rank_engine.sv
// tb_alphabet_rank_engine: randomized scoreboard bench for alphabet_rank_engine against an argmin reference model
module tb_alphabet_rank_engine;
    localparam int DW = 15, NC = 5, NL = 26, LW = 5, CW = 3, SW = 18, THR = 150000, LAT = 131;

    logic CLK = 1'b0;
    logic RST, ref_we, ref_clr, start, busy, done, no_match;
    logic [LW-1:0] ref_letter, best_letter;
    logic [CW-1:0] ref_ch;
    logic [DW-1:0] ref_data;
    logic [NC*DW-1:0] sensor_in;
    logic [SW-1:0] best_score;
`ifdef RANK_RUNNER_UP_EN
    logic [LW-1:0] second_letter;
    logic [SW-1:0] second_score;
`endif

    typedef struct {int cyc; int bl; int bs; int nm; int sl; int ss;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int refm[NL][NC];
    bit vm[NL];
    int checks = 0, errors = 0, cyc = 0;

    alphabet_rank_engine #(.MATCH_THRESH(18'd150000)) dut (
        .CLK(CLK), .RST(RST), .ref_we(ref_we), .ref_letter(ref_letter), .ref_ch(ref_ch),
        .ref_data(ref_data), .ref_clr(ref_clr), .start(start), .sensor_in(sensor_in),
        .busy(busy), .done(done), .best_letter(best_letter), .best_score(best_score),
        .no_match(no_match)
`ifdef RANK_RUNNER_UP_EN
        , .second_letter(second_letter), .second_score(second_score)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge CLK) begin
        if (!RST && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("best_letter", best_letter, mon_e.bl);
                chk("best_score", best_score, mon_e.bs);
                chk("no_match", no_match, mon_e.nm);
`ifdef RANK_RUNNER_UP_EN
                chk("second_letter", second_letter, mon_e.sl);
                chk("second_score", second_score, mon_e.ss);
`endif
            end
        end
    end

    function automatic exp_t model(input int s[NC]);
        exp_t e;
        int sc[NL];
        int b = -1, b2 = -1;
        for (int i = 0; i < NL; i++) begin
            sc[i] = 0;
            for (int j = 0; j < NC; j++)
                sc[i] += (s[j] > refm[i][j]) ? s[j] - refm[i][j] : refm[i][j] - s[j];
        end
        for (int i = 0; i < NL; i++) if (vm[i] && (b < 0 || sc[i] < sc[b])) b = i;
        for (int i = 0; i < NL; i++) if (vm[i] && i != b && (b2 < 0 || sc[i] < sc[b2])) b2 = i;
        e.cyc = cyc + LAT;
        e.bl = b < 0 ? (1 << LW) - 1 : b;
        e.bs = b < 0 ? (1 << SW) - 1 : sc[b];
        e.nm = (b < 0 || sc[b] > THR) ? 1 : 0;
        e.sl = b2 < 0 ? (1 << LW) - 1 : b2;
        e.ss = b2 < 0 ? (1 << SW) - 1 : sc[b2];
        return e;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic rand_sensor();
        for (int j = 0; j < NC; j++) sensor_in[j*DW +: DW] = DW'($urandom);
    endtask

    task automatic wr(input int l, input int c, input int d);
        ref_we = 1'b1;
        ref_letter = LW'(l);
        ref_ch = CW'(c);
        ref_data = DW'(d);
        tick();
        ref_we = 1'b0;
        if (l < NL && c < NC) begin
            refm[l][c] = d;
            vm[l] = 1'b1;
        end
    endtask

    task automatic clr();
        ref_clr = 1'b1;
        tick();
        ref_clr = 1'b0;
        foreach (vm[i]) vm[i] = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NL; i++) for (int j = 0; j < NC; j++) wr(i, j, 100 * i + j);
    endtask

    task automatic go(input int s[NC]);
        for (int j = 0; j < NC; j++) sensor_in[j*DW +: DW] = DW'(s[j]);
        start = 1'b1;
        sb.push_back(model(s));
        tick();
        start = 1'b0;
        rand_sensor();
    endtask

    task automatic wait_done();
        int i = 0;
        while (sb.size() != 0 && i < 400) begin
            tick();
            i++;
        end
        chk("result_timeout", sb.size(), 0);
        sb.delete();
        tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sb.delete();
        tick(2);
        RST = 1'b0;
        foreach (vm[i]) vm[i] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_best_letter"}, best_letter, 0);
        chk({tag, "_best_score"}, best_score, 0);
        chk({tag, "_no_match"}, no_match, 0);
`ifdef RANK_RUNNER_UP_EN
        chk({tag, "_second_letter"}, second_letter, 0);
        chk({tag, "_second_score"}, second_score, 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s[NC];
        RST = 1'b1; ref_we = 1'b0; ref_clr = 1'b0; start = 1'b0;
        ref_letter = '0; ref_ch = '0; ref_data = '0; sensor_in = '0;
        tick(3);
        RST = 1'b0;
        chk_zero("reset");

        load_ramp();
        for (int j = 0; j < NC; j++) s[j] = 700 + j;
        go(s);
        wait_done();

        clr();
        for (int j = 0; j < NC; j++) s[j] = $urandom_range(30000);
        for (int j = 0; j < NC; j++) begin
            wr(3, j, s[j]);
            wr(9, j, s[j]);
        end
        go(s);
        wait_done();

        do_reset();
        for (int j = 0; j < NC; j++) wr(5, j, 0);
        for (int j = 0; j < NC; j++) s[j] = 32767;
        go(s);
        wait_done();

        clr();
        rand_sensor();
        for (int j = 0; j < NC; j++) s[j] = $urandom_range(32767);
        go(s);
        wait_done();

        repeat (4) begin
            int pick;
            clr();
            for (int i = 0; i < NL; i++)
                if ($urandom_range(3) != 0)
                    for (int j = 0; j < NC; j++) wr(i, j, $urandom_range(32767));
            wr(28, 1, 5);
            wr(2, 6, 5);
            pick = $urandom_range(NL - 1);
            for (int j = 0; j < NC; j++)
                s[j] = $urandom_range(1) ? refm[pick][j] + $urandom_range(50) : $urandom_range(32767);
            for (int j = 0; j < NC; j++) if (s[j] > 32767) s[j] = 32767;
            go(s);
            wait_done();
        end

        clr();
        load_ramp();
        for (int j = 0; j < NC; j++) s[j] = 1200 + j;
        go(s);
        tick(39);
        chk("busy_mid_scan", busy, 1);
        for (int j = 0; j < NC; j++) sensor_in[j*DW +: DW] = DW'(300 + j);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(9);
        ref_we = 1'b1; ref_letter = 5'd12; ref_ch = 3'd0; ref_data = 15'd30000;
        tick();
        ref_we = 1'b0;
        ref_clr = 1'b1;
        tick();
        ref_clr = 1'b0;
        wait_done();
        go(s);
        wait_done();

        go(s);
        tick(59);
        RST = 1'b1;
        sb.delete();
        tick();
        RST = 1'b0;
        foreach (vm[i]) vm[i] = 1'b0;
        chk_zero("midscan_reset");
        tick(150);
        load_ramp();
        for (int j = 0; j < NC; j++) s[j] = 1900 + 2 * j;
        go(s);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
